// File: rtl/fio_host_ctrl.sv
// Host-side FileIO sequencer: loads TM/ICache/MEM/CLE from a valid/ready stream,
// kicks off execution, then streams a fixed MEM window back out with backpressure.
module fio_host_ctrl #(
  parameter int DATA_W          = 256,
  parameter int ICACHE_DEPTH    = 1024,
  parameter int MEM_TOTAL_DEPTH = 512,
  parameter int CLE_DEPTH       = 256,
  parameter int MEM_RD_LAT      = 1,
  parameter int START_CYCLES    = 2,
  parameter int DUMP_BASE       = 1,
  parameter int DUMP_COUNT      = 256,
  localparam int IA_W = $clog2(ICACHE_DEPTH),
  localparam int MA_W = $clog2(MEM_TOTAL_DEPTH),
  localparam int CA_W = $clog2(CLE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              Wen_FIO_TM,
  output logic [28:0]       Din_FIO_TM,
  output logic              start_FIO_TM,
  output logic              clear_FIO_TM,
  input  logic              finished_TM_FIO,
  output logic              Wen_FIO_ICache,
  output logic [IA_W-1:0]   Addr_FIO_ICache,
  output logic [31:0]       Din_FIO_ICache,
  output logic              Wen_FIO_MEM,
  output logic [MA_W-1:0]   Addr_FIO_MEM,
  output logic [DATA_W-1:0] Din_FIO_MEM,
  input  logic [DATA_W-1:0] Dout_FIO_MEM,
  output logic              Wen_FIO_CLE,
  output logic [CA_W-1:0]   Addr_FIO_CLE,
  output logic [4:0]        Din_FIO_CLE,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_HDR, S_LOAD, S_START, S_RUN, S_DUMP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                live_q, live_d;
  logic [1:0]          tgt_q, tgt_d;
  logic [11:0]         base_q, base_d;
  logic [15:0]         n_q, n_d, k_q, k_d, lat_q, lat_d;
  logic                err_q, err_d, clear_q, clear_d;
  logic                wen_tm_q, wen_tm_d, wen_ic_q, wen_ic_d;
  logic                wen_mem_q, wen_mem_d, wen_cle_q, wen_cle_d;
  logic [28:0]         din_tm_q, din_tm_d;
  logic [IA_W-1:0]     addr_ic_q, addr_ic_d;
  logic [31:0]         din_ic_q, din_ic_d;
  logic [MA_W-1:0]     addr_mem_q, addr_mem_d;
  logic [DATA_W-1:0]   din_mem_q, din_mem_d, mdata_q, mdata_d;
  logic [CA_W-1:0]     addr_cle_q, addr_cle_d;
  logic [4:0]          din_cle_q, din_cle_d;
  logic                mvalid_q, mvalid_d, mlast_q, mlast_d;

  logic [1:0]  h_tgt;
  logic        h_go, h_clr, acc;
  logic [11:0] h_base;
  logic [15:0] h_n;
  logic [31:0] h_depth;

  assign h_tgt  = s_data[1:0];
  assign h_go   = s_data[2];
  assign h_clr  = s_data[3];
  assign h_base = s_data[15:4];
  assign h_n    = s_data[31:16];
  assign acc    = s_valid & s_ready;

  // TM has no address port, so it can never overflow.
  always_comb begin
    h_depth = 32'hFFFF_FFFF;
    case (h_tgt)
      2'd1:    h_depth = 32'(ICACHE_DEPTH);
      2'd2:    h_depth = 32'(MEM_TOTAL_DEPTH);
      2'd3:    h_depth = 32'(CLE_DEPTH);
      default: h_depth = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HDR;   live_q <= 1'b0;     tgt_q <= '0;      base_q <= '0;
      n_q <= '0;          k_q <= '0;          lat_q <= '0;      err_q <= 1'b0;
      clear_q <= 1'b0;    wen_tm_q <= 1'b0;   din_tm_q <= '0;
      wen_ic_q <= 1'b0;   addr_ic_q <= '0;    din_ic_q <= '0;
      wen_mem_q <= 1'b0;  addr_mem_q <= '0;   din_mem_q <= '0;
      wen_cle_q <= 1'b0;  addr_cle_q <= '0;   din_cle_q <= '0;
      mvalid_q <= 1'b0;   mdata_q <= '0;      mlast_q <= 1'b0;
    end else begin
      state_q <= state_d; live_q <= live_d;   tgt_q <= tgt_d;   base_q <= base_d;
      n_q <= n_d;         k_q <= k_d;         lat_q <= lat_d;   err_q <= err_d;
      clear_q <= clear_d; wen_tm_q <= wen_tm_d; din_tm_q <= din_tm_d;
      wen_ic_q <= wen_ic_d;   addr_ic_q <= addr_ic_d;   din_ic_q <= din_ic_d;
      wen_mem_q <= wen_mem_d; addr_mem_q <= addr_mem_d; din_mem_q <= din_mem_d;
      wen_cle_q <= wen_cle_d; addr_cle_q <= addr_cle_d; din_cle_q <= din_cle_d;
      mvalid_q <= mvalid_d;   mdata_q <= mdata_d;       mlast_q <= mlast_d;
    end
  end

  always_comb begin
    state_d = state_q;  live_d = 1'b1;       tgt_d = tgt_q;      base_d = base_q;
    n_d = n_q;          k_d = k_q;           lat_d = lat_q;      err_d = err_q;
    clear_d = 1'b0;     wen_tm_d = 1'b0;     din_tm_d = din_tm_q;
    wen_ic_d = 1'b0;    addr_ic_d = addr_ic_q;   din_ic_d = din_ic_q;
    wen_mem_d = 1'b0;   addr_mem_d = addr_mem_q; din_mem_d = din_mem_q;
    wen_cle_d = 1'b0;   addr_cle_d = addr_cle_q; din_cle_d = din_cle_q;
    mvalid_d = mvalid_q; mdata_d = mdata_q;  mlast_d = mlast_q;
    case (state_q)
      S_HDR, S_DONE: begin
        if (acc) begin
          clear_d = h_clr;
          tgt_d   = h_tgt;
          base_d  = h_base;
          n_d     = h_n;
          k_d     = '0;
          if (h_go) begin
            state_d = S_START;
          end else if (h_n != 16'd0) begin
            state_d = S_LOAD;
            if ((32'(h_base) + 32'(h_n)) > h_depth) err_d = 1'b1;
          end else begin
            state_d = S_HDR;
          end
        end
      end
      S_LOAD: begin
        if (acc) begin
          case (tgt_q)
            2'd0: begin wen_tm_d = 1'b1; din_tm_d = s_data[28:0]; end
            2'd1: begin
              wen_ic_d  = 1'b1;
              addr_ic_d = IA_W'(32'(base_q) + 32'(k_q));
              din_ic_d  = s_data[31:0];
            end
            2'd2: begin
              wen_mem_d  = 1'b1;
              addr_mem_d = MA_W'(32'(base_q) + 32'(k_q));
              din_mem_d  = s_data;
            end
            default: begin
              wen_cle_d  = 1'b1;
              addr_cle_d = CA_W'(32'(base_q) + 32'(k_q));
              din_cle_d  = s_data[4:0];
            end
          endcase
          k_d = k_q + 16'd1;
          if (k_q == n_q - 16'd1) state_d = S_HDR;
        end
      end
      S_START: begin
        k_d = k_q + 16'd1;
        if (k_q == 16'(START_CYCLES - 1)) begin
          state_d = S_RUN;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (finished_TM_FIO) begin
          state_d    = S_DUMP;
          addr_mem_d = MA_W'(DUMP_BASE);
          lat_d      = '0;
          k_d        = '0;
        end
      end
      S_DUMP: begin
        // One read in flight: capture after the latency, then hold until taken.
        if (!mvalid_q) begin
          if (lat_q == 16'(MEM_RD_LAT)) begin
            mdata_d  = Dout_FIO_MEM;
            mvalid_d = 1'b1;
            mlast_d  = (k_q == 16'(DUMP_COUNT - 1));
          end else begin
            lat_d = lat_q + 16'd1;
          end
        end else if (m_ready) begin
          mvalid_d = 1'b0;
          mlast_d  = 1'b0;
          if (mlast_q) begin
            state_d = S_DONE;
          end else begin
            addr_mem_d = addr_mem_q + MA_W'(1);
            k_d        = k_q + 16'd1;
            lat_d      = '0;
          end
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_comb begin
    s_ready      = live_q && (state_q == S_HDR || state_q == S_LOAD || state_q == S_DONE);
    busy         = (state_q == S_LOAD) || (state_q == S_START) ||
                   (state_q == S_RUN)  || (state_q == S_DUMP);
    done         = (state_q == S_DONE);
    start_FIO_TM = (state_q == S_START);
  end

  assign m_valid         = mvalid_q;
  assign m_data          = mdata_q;
  assign m_last          = mlast_q;
  assign Wen_FIO_TM      = wen_tm_q;
  assign Din_FIO_TM      = din_tm_q;
  assign clear_FIO_TM    = clear_q;
  assign Wen_FIO_ICache  = wen_ic_q;
  assign Addr_FIO_ICache = addr_ic_q;
  assign Din_FIO_ICache  = din_ic_q;
  assign Wen_FIO_MEM     = wen_mem_q;
  assign Addr_FIO_MEM    = addr_mem_q;
  assign Din_FIO_MEM     = din_mem_q;
  assign Wen_FIO_CLE     = wen_cle_q;
  assign Addr_FIO_CLE    = addr_cle_q;
  assign Din_FIO_CLE     = din_cle_q;
  assign err             = err_q;

endmodule

// File: tb/tb_fio_host_ctrl.sv
// Bench for fio_host_ctrl: table-driven loads, go/dump with backpressure,
// mid-load reset and randomized loads against a reference memory image.
module tb_fio_host_ctrl;
  localparam int DW = 64, ICD = 1024, MD = 512, CD = 256;
  localparam int LAT = 3, SC = 2, DB = 1, DC = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic s_valid = 1'b0, m_ready = 1'b0, finished_TM_FIO = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, m_valid, m_last, Wen_FIO_TM, start_FIO_TM, clear_FIO_TM;
  logic [DW-1:0] m_data, Din_FIO_MEM, Dout_FIO_MEM;
  logic [28:0] Din_FIO_TM;
  logic Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE, busy, done, err;
  logic [9:0] Addr_FIO_ICache;
  logic [31:0] Din_FIO_ICache;
  logic [8:0] Addr_FIO_MEM;
  logic [7:0] Addr_FIO_CLE;
  logic [4:0] Din_FIO_CLE;

  always #5 clk = ~clk;

  fio_host_ctrl #(.DATA_W(DW), .ICACHE_DEPTH(ICD), .MEM_TOTAL_DEPTH(MD), .CLE_DEPTH(CD),
    .MEM_RD_LAT(LAT), .START_CYCLES(SC), .DUMP_BASE(DB), .DUMP_COUNT(DC)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .Wen_FIO_TM(Wen_FIO_TM), .Din_FIO_TM(Din_FIO_TM), .start_FIO_TM(start_FIO_TM),
    .clear_FIO_TM(clear_FIO_TM), .finished_TM_FIO(finished_TM_FIO),
    .Wen_FIO_ICache(Wen_FIO_ICache), .Addr_FIO_ICache(Addr_FIO_ICache), .Din_FIO_ICache(Din_FIO_ICache),
    .Wen_FIO_MEM(Wen_FIO_MEM), .Addr_FIO_MEM(Addr_FIO_MEM), .Din_FIO_MEM(Din_FIO_MEM),
    .Dout_FIO_MEM(Dout_FIO_MEM), .Wen_FIO_CLE(Wen_FIO_CLE), .Addr_FIO_CLE(Addr_FIO_CLE),
    .Din_FIO_CLE(Din_FIO_CLE), .busy(busy), .done(done), .err(err));

  // MEM array with LAT-cycle synchronous read; shadow is the expected image.
  logic [DW-1:0] ram [MD];
  logic [DW-1:0] shadow [MD];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (Wen_FIO_MEM) ram[Addr_FIO_MEM] <= Din_FIO_MEM;
    rd_pipe[0] <= ram[Addr_FIO_MEM];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign Dout_FIO_MEM = rd_pipe[LAT-1];

  wire any_out = |{s_ready, m_valid, m_data, m_last, Wen_FIO_TM, Din_FIO_TM, start_FIO_TM,
                   clear_FIO_TM, Wen_FIO_ICache, Addr_FIO_ICache, Din_FIO_ICache, Wen_FIO_MEM,
                   Addr_FIO_MEM, Din_FIO_MEM, Wen_FIO_CLE, Addr_FIO_CLE, Din_FIO_CLE, busy, done, err};
  wire [2:0] wen_cnt = 3'(Wen_FIO_TM) + 3'(Wen_FIO_ICache) + 3'(Wen_FIO_MEM) + 3'(Wen_FIO_CLE);

  int n_tests = 0, n_fail = 0;
  int clr_cnt = 0, st_cnt = 0, multi_wen = 0;
  bit err_exp = 1'b0;

  always @(negedge clk) begin
    clr_cnt += int'(clear_FIO_TM);
    st_cnt  += int'(start_FIO_TM);
    if (wen_cnt > 3'd1) multi_wen++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] w, input int gap);
    int b;
    b = 0;
    repeat (gap) begin
      @(negedge clk);
      chk("gap_wen", 64'(wen_cnt), 0);
    end
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (b >= 50) chk("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] hdr(input logic [1:0] tgt, input bit go, input bit clr,
                                       input logic [11:0] base, input logic [15:0] n);
    return {$urandom, n, base, clr, go, tgt};
  endfunction

  task automatic do_load(input logic [1:0] tgt, input logic [11:0] base, input int n,
                         input logic [3:0][63:0] w, input logic [3:0][11:0] ea, input bit rnd_gap);
    send(hdr(tgt, 1'b0, 1'b0, base, 16'(n)), 0);
    for (int k = 0; k < n; k++) begin
      send(w[k], rnd_gap ? int'($urandom_range(0, 2)) : 0);
      @(negedge clk);
      chk("wen_onehot", 64'(wen_cnt), 1);
      case (tgt)
        2'd0: begin
          chk("tm_wen", Wen_FIO_TM, 1);
          chk("tm_din", Din_FIO_TM, w[k][28:0]);
        end
        2'd1: begin
          chk("ic_wen", Wen_FIO_ICache, 1);
          chk("ic_addr", Addr_FIO_ICache, ea[k]);
          chk("ic_din", Din_FIO_ICache, w[k][31:0]);
        end
        2'd2: begin
          chk("mem_wen", Wen_FIO_MEM, 1);
          chk("mem_addr", Addr_FIO_MEM, ea[k]);
          chk("mem_din", Din_FIO_MEM, w[k]);
          shadow[ea[k][8:0]] = w[k];
        end
        default: begin
          chk("cle_wen", Wen_FIO_CLE, 1);
          chk("cle_addr", Addr_FIO_CLE, ea[k]);
          chk("cle_din", Din_FIO_CLE, w[k][4:0]);
        end
      endcase
    end
    chk("load_end_busy", busy, 0);
    chk("err", err, err_exp);
  endtask

  // mode 0: always ready, 1: 5-cycle stall on the second row, 2: random ready
  task automatic do_dump(input int mode);
    int got, cyc, stall, s0;
    bit pv, phs, rdy;
    logic [DW-1:0] pd;
    got = 0; cyc = 0; stall = 0; pv = 0; phs = 0; pd = '0;
    s0 = st_cnt;
    send(hdr(2'($urandom_range(0, 3)), 1'b1, 1'b0, 12'h0, 16'($urandom_range(1, 9))), 0);
    repeat (SC + 3) @(negedge clk);
    chk("start_cycles", 64'(st_cnt - s0), SC);
    chk("run_busy", busy, 1);
    chk("run_s_ready", s_ready, 0);
    repeat (10) @(negedge clk);
    chk("run_no_valid", m_valid, 0);
    finished_TM_FIO = 1'b1;
    @(negedge clk);
    finished_TM_FIO = 1'b0;
    while (got < DC && cyc < 300) begin
      if (pv && !phs) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
      end
      case (mode)
        0: rdy = 1'b1;
        1: begin
          rdy = 1'b1;
          if (m_valid && got == 1 && stall < 5) begin rdy = 1'b0; stall++; end
        end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready = rdy;
      phs = m_valid && rdy;
      pv  = m_valid;
      pd  = m_data;
      if (phs) begin
        chk("dump_data", m_data, shadow[(DB + got) % MD]);
        chk("dump_last", m_last, 64'(got == DC - 1));
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < DC) chk("dump_timeout_rows", 64'(got), DC);
    m_ready = 1'b0;
    chk("done_high", done, 1);
    chk("done_busy", busy, 0);
    chk("done_m_valid", m_valid, 0);
    chk("done_s_ready", s_ready, 1);
    send(hdr(2'd0, 1'b0, 1'b0, 12'h0, 16'd0), 0);
    @(negedge clk);
    chk("done_falls", done, 0);
  endtask

  typedef struct packed {
    logic [1:0]        tgt;
    logic [11:0]       base;
    logic [2:0]        n;
    logic              clr;
    logic [3:0][63:0]  w;
    logic [3:0][11:0]  ea;
    logic              err;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int c0;
    logic [29:0] snap;
    logic [1:0] tgt;
    logic [11:0] base;
    int n, depth;
    logic [3:0][63:0] w;
    logic [3:0][11:0] ea;

    for (int i = 0; i < MD; i++) begin
      ram[i] = {$urandom, $urandom};
      shadow[i] = ram[i];
    end
    tbl[0] = '{tgt: 2'd1, base: 12'h010, n: 3'd3, clr: 1'b0,
               w: {64'h0, 64'hC0C0_C0C0_3333_3333, 64'hB0B0_B0B0_2222_2222, 64'hA0A0_A0A0_1111_1111},
               ea: {12'h0, 12'h012, 12'h011, 12'h010}, err: 1'b0};
    tbl[1] = '{tgt: 2'd0, base: 12'h055, n: 3'd2, clr: 1'b1,
               w: {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0},
               ea: {12'h0, 12'h0, 12'h0, 12'h0}, err: 1'b0};
    tbl[2] = '{tgt: 2'd3, base: 12'h020, n: 3'd2, clr: 1'b0,
               w: {64'h0, 64'h0, 64'h0000_0000_0000_003F, 64'h0000_0000_0000_0015},
               ea: {12'h0, 12'h0, 12'h021, 12'h020}, err: 1'b0};
    tbl[3] = '{tgt: 2'd2, base: 12'h1FF, n: 3'd2, clr: 1'b0,
               w: {64'h0, 64'h0, 64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444},
               ea: {12'h0, 12'h0, 12'h000, 12'h1FF}, err: 1'b1};
    tbl[4] = '{tgt: 2'd2, base: 12'h002, n: 3'd3, clr: 1'b0,
               w: {64'h0, 64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002},
               ea: {12'h0, 12'h004, 12'h003, 12'h002}, err: 1'b1};
    tbl[5] = '{tgt: 2'd1, base: 12'h405, n: 3'd1, clr: 1'b0,
               w: {64'h0, 64'h0, 64'h0, 64'h0BAD_F00D_CAFE_BABE},
               ea: {12'h0, 12'h0, 12'h0, 12'h005}, err: 1'b1};
    tbl[6] = '{tgt: 2'd3, base: 12'h0FE, n: 3'd3, clr: 1'b0,
               w: {64'h0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_001E, 64'h0000_0000_0000_000B},
               ea: {12'h0, 12'h000, 12'h0FF, 12'h0FE}, err: 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_outs", any_out, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].clr) begin
        c0 = clr_cnt;
        send(hdr(2'd0, 1'b0, 1'b1, 12'h0, 16'd0), 0);
        repeat (3) @(negedge clk);
        chk("clear_pulse", 64'(clr_cnt - c0), 1);
      end
      snap = {Addr_FIO_ICache, Addr_FIO_MEM, Addr_FIO_CLE};
      err_exp = tbl[i].err;
      do_load(tbl[i].tgt, tbl[i].base, int'(tbl[i].n), tbl[i].w, tbl[i].ea, 1'b0);
      if (tbl[i].tgt == 2'd0)
        chk("tm_no_addr", {Addr_FIO_ICache, Addr_FIO_MEM, Addr_FIO_CLE}, snap);
    end

    do_dump(0);
    do_dump(1);

    // Reset in the middle of a 3-word ICache load.
    send(hdr(2'd1, 1'b0, 1'b0, 12'h040, 16'd3), 0);
    send(64'hAAAA_0000_0000_0001, 0);
    @(negedge clk);
    chk("pre_reset_wen", Wen_FIO_ICache, 1);
    #2 rst = 1'b0;
    #1 chk("midload_reset_outs", any_out, 0);
    @(negedge clk);
    rst = 1'b1;
    err_exp = 1'b0;
    @(negedge clk);
    do_load(2'd1, 12'h050, 1, {192'h0, 64'h5050_5050_5050_5050}, {36'h0, 12'h050}, 1'b0);

    for (int r = 0; r < 20; r++) begin
      tgt  = 2'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 4));
      base = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 6)) : 12'($urandom_range(0, 4095));
      depth = (tgt == 2'd1) ? ICD : (tgt == 2'd2) ? MD : CD;
      for (int k = 0; k < 4; k++) begin
        w[k]  = {$urandom, $urandom};
        ea[k] = 12'((int'(base) + k) % depth);
      end
      if (tgt != 2'd0 && int'(base) + n > depth) err_exp = 1'b1;
      do_load(tgt, base, n, w, ea, 1'b1);
    end
    do_dump(2);

    chk("never_two_wen", 64'(multi_wen), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
